// File: rtl/imm_encoder_if.sv
// rtl/imm_encoder_if.sv - request/result bundle for the immediate encoder
interface imm_encoder_if;
    logic        start;
    logic [31:0] Value;
    logic [1:0]  ImmSrc;
    logic        busy;
    logic        done;
    logic        ok;
    logic [23:0] Instr;

    modport master (output start, Value, ImmSrc, input busy, done, ok, Instr);
    modport slave  (input start, Value, ImmSrc, output busy, done, ok, Instr);
endinterface

// File: rtl/imm_encoder.sv
// rtl/imm_encoder.sv - encodes a 32-bit constant into an imm8/imm12/imm24 instruction field
// Optional feature macro: IMM_ENC_ROT_IMM_EN (rotation search r=0..15 for ImmSrc=00)
module imm_encoder (
    input  logic         clk,
    input  logic         reset_n,
    imm_encoder_if.slave bus
);
    typedef enum logic {IDLE, SEARCH} state_t;

`ifdef IMM_ENC_ROT_IMM_EN
    localparam logic [3:0] LAST_R = 4'd15;
`else
    localparam logic [3:0] LAST_R = 4'd0;
`endif

    state_t      state_q, state_d;
    logic [31:0] val_q;
    logic [1:0]  src_q;
    logic [3:0]  r_q;
    logic        done_q, ok_q;
    logic [23:0] instr_q;

    logic        resolve;
    logic        res_ok;
    logic [23:0] res_instr;
    logic [4:0]  sh;
    logic [31:0] cand;

    // Candidate is the captured value rotated left by 2*r
    assign sh   = {r_q, 1'b0};
    assign cand = (val_q << sh) | (val_q >> (6'd32 - {1'b0, sh}));

    always_comb begin
        state_d   = state_q;
        resolve   = 1'b0;
        res_ok    = 1'b0;
        res_instr = 24'h000000;
        case (state_q)
            IDLE: begin
                if (bus.start) state_d = SEARCH;
            end
            SEARCH: begin
                case (src_q)
                    2'b00: begin
                        if (cand[31:8] == 24'h000000) begin
                            resolve = 1'b1;
                            res_ok  = 1'b1;
`ifdef IMM_ENC_ROT_IMM_EN
                            res_instr = {12'h000, r_q, cand[7:0]};
`else
                            res_instr = {12'h000, 4'h0, cand[7:0]};
`endif
                        end else if (r_q == LAST_R) begin
                            resolve = 1'b1;
                        end
                    end
                    2'b01: begin
                        resolve = 1'b1;
                        if (val_q[31:12] == 20'h00000) begin
                            res_ok    = 1'b1;
                            res_instr = {12'h000, val_q[11:0]};
                        end
                    end
                    2'b10: begin
                        resolve = 1'b1;
                        if (val_q[1:0] == 2'b00 &&
                            (val_q[31:25] == 7'h00 || val_q[31:25] == 7'h7f)) begin
                            res_ok    = 1'b1;
                            res_instr = val_q[25:2];
                        end
                    end
                    default: resolve = 1'b1;
                endcase
                if (resolve) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            val_q   <= 32'h0;
            src_q   <= 2'b00;
            r_q     <= 4'h0;
            done_q  <= 1'b0;
            ok_q    <= 1'b0;
            instr_q <= 24'h000000;
        end else begin
            state_q <= state_d;
            done_q  <= resolve;
            if (state_q == IDLE && bus.start) begin
                val_q <= bus.Value;
                src_q <= bus.ImmSrc;
                r_q   <= 4'h0;
            end else if (state_q == SEARCH && !resolve && r_q != 4'hf) begin
                r_q <= r_q + 4'h1;
            end
            // Result registers hold until the next resolve, not cleared by start
            if (resolve) begin
                ok_q    <= res_ok;
                instr_q <= res_instr;
            end
        end
    end

    assign bus.busy  = (state_q == SEARCH);
    assign bus.done  = done_q;
    assign bus.ok    = ok_q;
    assign bus.Instr = instr_q;
endmodule
